// File: rtl/alu_pkg.sv
// Shared opcode encodings and loader FSM state type for the ALU front-end.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_MAX = 4'b1001;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } loader_state_t;

    function automatic logic isDivideOp(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_operand_loader_debouncer.sv
// Synchronises a raw active-low pushbutton, debounces it and emits a single-cycle pulse per press.
module button_debouncer #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The level flips only after DEB_CYCLES consecutive samples disagree with it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Board front-end for the ALU: loads A, B and opcode from switches on key presses,
// then captures the combinational ALU result and flags one cycle later for display.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_data,
    input  logic [3:0]   sw_op,
    input  logic         key_next_n,
    input  logic         key_clr_n,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   operator,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         div0_err,
    output logic         op_err,
    output logic         done,
    output logic [2:0]   state_dbg
);

    logic          nextPress, clrPress;
    logic [N-1:0]  swDataMeta_q, swDataSync_q;
    logic [3:0]    swOpMeta_q, swOpSync_q;

    loader_state_t state_q, state_d;
    logic [N-1:0]  opA_q, opA_d, opB_q, opB_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [N-1:0]  resCap_q, resCap_d;
    logic [3:0]    flagsCap_q, flagsCap_d;
    logic          div0_q, div0_d;
    logic          opErr_q, opErr_d;
    logic          done_q, done_d;

    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_next_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_next_n),
        .press (nextPress)
    );

    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clr_n),
        .press (clrPress)
    );

    // EXEC ignores both keys so operands stay stable while the ALU settles.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        opcode_d   = opcode_q;
        resCap_d   = resCap_q;
        flagsCap_d = flagsCap_q;
        div0_d     = div0_q;
        opErr_d    = 1'b0;
        done_d     = 1'b0;
        if (clrPress && state_q != EXEC) begin
            state_d  = LOAD_A;
            opA_d    = '0;
            opB_d    = '0;
            opcode_d = '0;
            div0_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: if (nextPress) begin
                    opA_d   = swDataSync_q;
                    state_d = LOAD_B;
                end
                LOAD_B: if (nextPress) begin
                    opB_d   = swDataSync_q;
                    state_d = LOAD_OP;
                end
                LOAD_OP: if (nextPress) begin
                    if (swOpSync_q <= OP_MAX) begin
                        opcode_d = swOpSync_q;
                        state_d  = EXEC;
                    end else begin
                        opErr_d = 1'b1;
                    end
                end
                EXEC: begin
                    resCap_d   = alu_result;
                    flagsCap_d = alu_flags;
                    div0_d     = isDivideOp(opcode_q) && (opB_q == '0);
                    done_d     = 1'b1;
                    state_d    = SHOW;
                end
                SHOW: if (nextPress) state_d = LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swDataMeta_q <= '0;
            swDataSync_q <= '0;
            swOpMeta_q   <= '0;
            swOpSync_q   <= '0;
            state_q      <= LOAD_A;
            opA_q        <= '0;
            opB_q        <= '0;
            opcode_q     <= '0;
            resCap_q     <= '0;
            flagsCap_q   <= '0;
            div0_q       <= 1'b0;
            opErr_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            swDataMeta_q <= sw_data;
            swDataSync_q <= swDataMeta_q;
            swOpMeta_q   <= sw_op;
            swOpSync_q   <= swOpMeta_q;
            state_q      <= state_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            opcode_q     <= opcode_d;
            resCap_q     <= resCap_d;
            flagsCap_q   <= flagsCap_d;
            div0_q       <= div0_d;
            opErr_q      <= opErr_d;
            done_q       <= done_d;
        end
    end

    assign a         = opA_q;
    assign b         = opB_q;
    assign operator  = opcode_q;
    assign result_q  = resCap_q;
    assign flags_q   = flagsCap_q;
    assign div0_err  = div0_q;
    assign op_err    = opErr_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with a small behavioural 4-bit ALU attached.
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [N-1:0] swData;
    logic [3:0]   swOp;
    logic         keyNext, keyClr;
    logic [N-1:0] aW, bW, resultQ;
    logic [3:0]   operatorW, flagsQ;
    logic         div0Err, opErr, done;
    logic [2:0]   stateDbg;
    logic [N-1:0] aluResult;
    logic [3:0]   aluFlags;
    logic [7:0]   prod;
    logic         cFlag, vFlag;

    alu_operand_loader #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_data    (swData),
        .sw_op      (swOp),
        .key_next_n (keyNext),
        .key_clr_n  (keyClr),
        .alu_result (aluResult),
        .alu_flags  (aluFlags),
        .a          (aW),
        .b          (bW),
        .operator   (operatorW),
        .result_q   (resultQ),
        .flags_q    (flagsQ),
        .div0_err   (div0Err),
        .op_err     (opErr),
        .done       (done),
        .state_dbg  (stateDbg)
    );

    // Behavioural ALU, flags packed as {N,Z,C,V}.
    always_comb begin
        aluResult = '0;
        cFlag     = 1'b0;
        vFlag     = 1'b0;
        prod      = '0;
        case (operatorW)
            OP_ADD: begin
                {cFlag, aluResult} = {1'b0, aW} + {1'b0, bW};
                vFlag = (aW[3] == bW[3]) && (aluResult[3] != aW[3]);
            end
            OP_SUB: begin
                aluResult = aW - bW;
                cFlag     = aW < bW;
                vFlag     = (aW[3] != bW[3]) && (aluResult[3] != aW[3]);
            end
            OP_MUL: begin
                prod      = aW * bW;
                aluResult = prod[3:0];
                cFlag     = |prod[7:4];
            end
            OP_DIV: aluResult = (bW == '0) ? '0 : aW / bW;
            OP_MOD: aluResult = (bW == '0) ? '0 : aW % bW;
            OP_AND: aluResult = aW & bW;
            OP_OR:  aluResult = aW | bW;
            OP_XOR: aluResult = aW ^ bW;
            OP_SHL: aluResult = aW << bW;
            OP_SHR: aluResult = aW >> bW;
            default: aluResult = '0;
        endcase
        aluFlags = {aluResult[3], aluResult == '0, cFlag, vFlag};
    end

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic       div0;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int errors = 0;
    int opErrCount = 0;
    bit found;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor pops one expected capture every time done pulses.
    always @(negedge clk) begin
        expect_t e;
        if (opErr === 1'b1) opErrCount++;
        if (done === 1'b1) begin
            checkOutput("done with result pending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("result_q", 32'(resultQ), 32'(e.res));
                checkOutput("flags_q", 32'(flagsQ), 32'(e.flags));
                checkOutput("div0_err", 32'(div0Err), 32'(e.div0));
                checkOutput("a held", 32'(aW), 32'(e.a));
                checkOutput("b held", 32'(bW), 32'(e.b));
                checkOutput("operator held", 32'(operatorW), 32'(e.op));
                checkOutput("state on done", 32'(stateDbg), 32'(SHOW));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] data, input logic [3:0] op,
                                 input bit useNext, input bit useClr, input int hold);
        @(negedge clk);
        swData = data;
        swOp   = op;
        waitCycles(3);
        keyNext = ~useNext;
        keyClr  = ~useClr;
        waitCycles(hold);
        keyNext = 1'b1;
        keyClr  = 1'b1;
        waitCycles(DEB + 6);
    endtask

    task automatic commitUntilExec(input logic [3:0] op, output bit hit);
        @(negedge clk);
        swOp = op;
        waitCycles(3);
        keyNext = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stateDbg == EXEC) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic runOp(input logic [3:0] opA, input logic [3:0] opB, input logic [3:0] op,
                         input logic [3:0] expRes, input logic [3:0] expFlags, input logic expDiv0,
                         input bit loadOperands);
        bit hit;
        if (loadOperands) begin
            applyStimulus(opA, 4'h0, 1'b1, 1'b0, 12);
            applyStimulus(opB, 4'h0, 1'b1, 1'b0, 12);
        end
        expQ.push_back('{expRes, expFlags, expDiv0, opA, opB, op});
        commitUntilExec(op, hit);
        checkOutput("exec reached", 32'(hit), 32'd1);
        @(negedge clk);
        checkOutput("done one cycle after exec", 32'(done), 32'd1);
        keyNext = 1'b1;
        waitCycles(DEB + 6);
        applyStimulus(4'h0, 4'h0, 1'b1, 1'b0, 12);
        checkOutput("back to LOAD_A", 32'(stateDbg), 32'(LOAD_A));
        checkOutput("result held after SHOW", 32'(resultQ), 32'(expRes));
    endtask

    initial begin
        rst_n   = 1'b0;
        swData  = '0;
        swOp    = '0;
        keyNext = 1'b1;
        keyClr  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset a", 32'(aW), 32'd0);
        checkOutput("reset b", 32'(bW), 32'd0);
        checkOutput("reset operator", 32'(operatorW), 32'd0);
        checkOutput("reset result_q", 32'(resultQ), 32'd0);
        checkOutput("reset flags_q", 32'(flagsQ), 32'd0);
        checkOutput("reset div0_err", 32'(div0Err), 32'd0);
        checkOutput("reset op_err", 32'(opErr), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset state", 32'(stateDbg), 32'(LOAD_A));
        @(negedge clk);
        rst_n = 1'b1;

        // Long hold must advance exactly one state.
        applyStimulus(4'h5, 4'h0, 1'b1, 1'b0, 20);
        checkOutput("long hold single press", 32'(stateDbg), 32'(LOAD_B));
        checkOutput("a loaded", 32'(aW), 32'h5);

        // Short bounces never reach the debounce threshold.
        @(negedge clk);
        swData = 4'h3;
        waitCycles(3);
        for (int i = 0; i < 2; i++) begin
            keyNext = 1'b0;
            waitCycles(2);
            keyNext = 1'b1;
            waitCycles(2);
        end
        waitCycles(DEB + 6);
        checkOutput("bounce ignored state", 32'(stateDbg), 32'(LOAD_B));
        checkOutput("bounce ignored b", 32'(bW), 32'h0);
        applyStimulus(4'h3, 4'h0, 1'b1, 1'b0, 12);
        checkOutput("stable press after bounce", 32'(stateDbg), 32'(LOAD_OP));
        checkOutput("b loaded", 32'(bW), 32'h3);

        // 5+3 = 8: N and V set.
        runOp(4'h5, 4'h3, OP_ADD, 4'h8, 4'b1001, 1'b0, 1'b0);
        // 3-5 = E with borrow.
        runOp(4'h3, 4'h5, OP_SUB, 4'hE, 4'b1010, 1'b0, 1'b1);
        // 5*4 = 0x14 truncates to 4 with carry.
        runOp(4'h5, 4'h4, OP_MUL, 4'h4, 4'b0010, 1'b0, 1'b1);

        // Illegal opcode is rejected, then divide by zero is flagged.
        applyStimulus(4'h7, 4'h0, 1'b1, 1'b0, 12);
        applyStimulus(4'h0, 4'h0, 1'b1, 1'b0, 12);
        applyStimulus(4'h0, 4'hC, 1'b1, 1'b0, 12);
        checkOutput("op_err pulse seen", 32'(opErrCount), 32'd1);
        checkOutput("stay in LOAD_OP", 32'(stateDbg), 32'(LOAD_OP));
        checkOutput("operator unchanged", 32'(operatorW), 32'(OP_MUL));
        runOp(4'h7, 4'h0, OP_DIV, 4'h0, 4'b0100, 1'b1, 1'b0);

        // Simultaneous next and clr: clr wins.
        applyStimulus(4'h9, 4'h0, 1'b1, 1'b0, 12);
        applyStimulus(4'h6, 4'h0, 1'b1, 1'b0, 12);
        checkOutput("ready to commit", 32'(stateDbg), 32'(LOAD_OP));
        applyStimulus(4'h0, OP_XOR, 1'b1, 1'b1, 12);
        checkOutput("clr wins state", 32'(stateDbg), 32'(LOAD_A));
        checkOutput("clr a", 32'(aW), 32'h0);
        checkOutput("clr b", 32'(bW), 32'h0);
        checkOutput("clr operator", 32'(operatorW), 32'h0);
        checkOutput("clr div0_err", 32'(div0Err), 32'h0);
        checkOutput("clr keeps flags_q", 32'(flagsQ), 32'b0100);

        // Reset while in EXEC: nothing is captured and done never fires.
        applyStimulus(4'h2, 4'h0, 1'b1, 1'b0, 12);
        applyStimulus(4'h2, 4'h0, 1'b1, 1'b0, 12);
        commitUntilExec(OP_ADD, found);
        checkOutput("exec reached before reset", 32'(found), 32'd1);
        rst_n   = 1'b0;
        keyNext = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid reset state", 32'(stateDbg), 32'(LOAD_A));
        checkOutput("mid reset result_q", 32'(resultQ), 32'h0);
        checkOutput("mid reset flags_q", 32'(flagsQ), 32'h0);
        checkOutput("mid reset done", 32'(done), 32'h0);
        checkOutput("mid reset a", 32'(aW), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("no pulse survives reset", 32'(stateDbg), 32'(LOAD_A));

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        checkOutput("total op_err pulses", 32'(opErrCount), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
